// File: rtl/coin_acceptor_encoder.sv
// coin_acceptor_encoder: coin-mechanism front end for the vending controller.
// Synchronises and debounces the two raw coin sensors, turns each clean
// insertion into a token queued in a small FIFO, and paces the tokens out
// as one-cycle coin codes separated by idle gaps.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   coin5_raw   raw 5-unit sensor (asynchronous, bouncy)
//   coin10_raw  raw 10-unit sensor (asynchronous, bouncy)
//   vend_busy   controller dispensing; holds off new emissions
//   coin_code   00 none, 01 five, 10 ten (registered)
//   coin_reject one-cycle pulse when a detected coin is dropped (registered)
//   fifo_level  queued token count (registered)
module coin_acceptor_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned GAP_CYCLES      = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin5_raw,
   input  logic       coin10_raw,
   input  logic       vend_busy,
   output logic [1:0] coin_code,
   output logic       coin_reject,
   output logic [2:0] fifo_level
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned GAP_W = 4;
   localparam int unsigned LVL_W = 3;
   localparam int unsigned SPC_W = 4;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned MEM_N = 1 << PTR_W;

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

   // Channel index 0 = 5-unit slot, 1 = 10-unit slot.
   logic [1:0]            sync1_q, sync2_q;
   logic [1:0]            deb_q, deb_d, deb_prev_q;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            tok_c;

   // FIFO storage: one bit per slot, 1 = ten-unit token.
   logic [MEM_N-1:0]      mem_q, mem_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [SPC_W-1:0]      space_c;
   logic [1:0]            n_wr_c;
   logic                  reject_q, reject_d;

   state_t                state_q, state_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic [1:0]            code_q, code_d;
   logic                  pop_c, can_pop_c;
   logic [1:0]            head_code_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Debounce: a level is accepted after DEBOUNCE_CYCLES consecutive mismatches.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      for (int c = 0; c < 2; c++) begin
         if (sync2_q[c] != deb_q[c]) begin
            if (cnt_q[c] == CNT_W'(DEBOUNCE_CYCLES - 1)) deb_d[c] = sync2_q[c];
            else                                         cnt_d[c] = cnt_q[c] + CNT_W'(1);
         end
      end
   end

   assign tok_c       = deb_q & ~deb_prev_q;
   assign head_code_c = mem_q[rd_ptr_q] ? 2'b10 : 2'b01;
   assign can_pop_c   = (level_q != '0) && !vend_busy;

   // Emission FSM. The last gap cycle also makes the IDLE pop decision so
   // codes can run at one per (1 + GAP_CYCLES) cycles.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      code_d  = 2'b00;
      pop_c   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (can_pop_c) begin
               pop_c   = 1'b1;
               code_d  = head_code_c;
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            gap_d   = '0;
            state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               if (can_pop_c) begin
                  pop_c   = 1'b1;
                  code_d  = head_code_c;
                  state_d = S_EMIT;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO write: T5 ahead of T10, space counted after a same-cycle pop.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      n_wr_c   = 2'd0;
      reject_d = 1'b0;
      space_c  = SPC_W'(FIFO_DEPTH) - SPC_W'(level_q) + SPC_W'(pop_c);
      if (tok_c == 2'b11) begin
         if (space_c >= SPC_W'(2)) begin
            mem_d[wr_ptr_q]          = 1'b0;
            mem_d[ptr_inc(wr_ptr_q)] = 1'b1;
            wr_ptr_d                 = ptr_inc(ptr_inc(wr_ptr_q));
            n_wr_c                   = 2'd2;
         end else if (space_c == SPC_W'(1)) begin
            mem_d[wr_ptr_q] = 1'b0;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            n_wr_c          = 2'd1;
            reject_d        = 1'b1;
         end else begin
            reject_d = 1'b1;
         end
      end else if (tok_c != 2'b00) begin
         if (space_c != '0) begin
            mem_d[wr_ptr_q] = tok_c[1];
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            n_wr_c          = 2'd1;
         end else begin
            reject_d = 1'b1;
         end
      end
      rd_ptr_d = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      level_d  = level_q + LVL_W'(n_wr_c) - LVL_W'(pop_c);
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         cnt_q      <= '0;
         mem_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         reject_q   <= 1'b0;
         state_q    <= S_IDLE;
         gap_q      <= '0;
         code_q     <= 2'b00;
      end else begin
         sync1_q    <= {coin10_raw, coin5_raw};
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         reject_q   <= reject_d;
         state_q    <= state_d;
         gap_q      <= gap_d;
         code_q     <= code_d;
      end
   end

   assign coin_code   = code_q;
   assign coin_reject = reject_q;
   assign fifo_level  = level_q;

endmodule
